mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the core's single memory port: IFU (instruction fetch) and LSU (load/store).
- Serialises both onto one valid/ready request channel with a single-cycle response pulse, one transaction outstanding at a time.
- Fixed LSU priority, with a starvation guard so fetch always makes progress.
- Sits between IFU/LSU and the DPI-backed memory wrapper; sub-word load alignment stays in the LSU.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (wmask width = DATA_W/8)
MAX_LS_STREAK, 4, max consecutive LSU grants while IFU is waiting; range 1..15

Ports:
clk  input  1  clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
if_valid  input  1  IFU request pending
if_addr  input  ADDR_W  fetch address
if_ready  output  1  IFU request accepted by memory (1-cycle pulse)
if_rvalid  output  1  fetch data valid (1-cycle pulse)
if_rdata  output  DATA_W  fetch data
ls_valid  input  1  LSU request pending
ls_addr  input  ADDR_W  load/store address
ls_wen  input  1  1=store, 0=load
ls_wdata  input  DATA_W  store data
ls_wmask  input  DATA_W/8  store byte mask
ls_ready  output  1  LSU request accepted (1-cycle pulse)
ls_rvalid  output  1  load data / store ack valid (1-cycle pulse)
ls_rdata  output  DATA_W  load data; don't-care for stores
mem_valid  output  1  request to memory
mem_addr  output  ADDR_W  request address
mem_wen  output  1  write enable
mem_wdata  output  DATA_W  write data
mem_wmask  output  DATA_W/8  write mask
mem_ready  input  1  memory accepts request
mem_rvalid  input  1  memory response (1-cycle pulse)
mem_rdata  input  DATA_W  response data

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: FSM=IDLE, owner=none, streak=0. All outputs 0, including the mem_* request registers and the rdata regs. Reset mid-transaction aborts it with no response pulse; a later stray mem_rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any valid, grant and latch the owner's addr/wen/wdata/wmask into the mem_* registers, then go to REQ. For IFU, latch mem_wen=0 and mem_wmask=0.
- Grant rule: grant LSU if ls_valid && !(if_valid && streak==MAX_LS_STREAK). Otherwise grant IFU if if_valid.
- Streak counter:
  - LSU grant with if_valid=1: streak+1, saturating.
  - LSU grant with if_valid=0: streak cleared to 0.
  - IFU grant: streak cleared to 0.
- REQ: mem_valid=1, mem_* held stable. On mem_ready=1, pulse owner's x_ready that same cycle (combinational from mem_ready and state) and go to WAIT. mem_rvalid in REQ is ignored.
- WAIT: mem_valid=0. On mem_rvalid=1, register mem_rdata into owner's rdata reg and go to RESP. Unbounded wait, no timeout.
- RESP: owner's x_rvalid=1 for exactly one cycle. rdata reg holds its value until the next response to that owner. Next state is IDLE.
- Minimum latency: valid at cycle 0 (IDLE) → mem_valid and x_ready at cycle 1 (mem_ready=1) → mem_rvalid at cycle 2 → x_rvalid at cycle 3 → IDLE at cycle 4. Throughput is one transaction per 4 cycles at best.
- Requesters must hold x_valid and payload until x_ready. If valid drops after grant, the latched transaction still completes and the response is still delivered.
- Requests arriving in REQ/WAIT/RESP are not sampled until IDLE. The non-owner's x_ready and x_rvalid stay 0 throughout.
- Never more than one of if_ready/ls_ready, or of if_rvalid/ls_rvalid, high in a cycle.

Test Plan:
- Reset/idle: rst_n=0 with if_valid=ls_valid=1 → all outputs 0. Release with no valids → mem_valid stays 0 for 10 cycles.
- Single fetch, if_addr=0x80000000, mem_ready and mem_rvalid asserted immediately with mem_rdata=0x0000001300000093 → mem_addr=0x80000000, mem_wen=0, if_ready at cycle 1, if_rvalid at cycle 3 with if_rdata=0x0000001300000093, ls_* outputs all 0.
- Store, ls_addr=0x80001004, ls_wdata=0xDEADBEEF, ls_wmask=0xF0, mem_ready delayed 3 cycles → mem_valid high 4 cycles with payload stable; ls_ready pulses on the 4th; ls_rvalid one cycle after mem_rvalid.
- Priority/starvation, MAX_LS_STREAK=4, if_valid and ls_valid held high → grant sequence LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- Simultaneous valids, streak=0 → LSU served first, IFU next. Stray mem_rvalid during REQ → no rvalid pulse, FSM stays in REQ.
- Async reset in WAIT, then mem_rvalid after release → no x_rvalid. Next if_valid is served normally with streak=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter onto a single valid/ready memory port
// One transaction outstanding; LSU has priority, bounded by a streak guard for fetch.
module mem_arbiter #(
   parameter int ADDR_W        = 64,
   parameter int DATA_W        = 64,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_valid,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ready,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_valid,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic                ls_wen,
   input  logic [DATA_W-1:0]   ls_wdata,
   input  logic [DATA_W/8-1:0] ls_wmask,
   output logic                ls_ready,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MW = DATA_W / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_LS   = 2'd2;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

   logic [1:0]        state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [3:0]        streak_q, streak_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wen_q, mem_wen_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [MW-1:0]     mem_wmask_q, mem_wmask_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              grant_ls;

   // LSU wins unless fetch is waiting and the LSU has used up its streak.
   assign grant_ls = ls_valid && !(if_valid && (streak_q == STREAK_MAX));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      mem_addr_d  = mem_addr_q;
      mem_wen_d   = mem_wen_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (grant_ls) begin
               owner_d     = OWN_LS;
               mem_addr_d  = ls_addr;
               mem_wen_d   = ls_wen;
               mem_wdata_d = ls_wdata;
               mem_wmask_d = ls_wmask;
               if (!if_valid)
                  streak_d = 4'd0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + 4'd1;
               state_d     = S_REQ;
            end else if (if_valid) begin
               owner_d     = OWN_IF;
               mem_addr_d  = if_addr;
               mem_wen_d   = 1'b0;
               mem_wdata_d = '0;
               mem_wmask_d = '0;
               streak_d    = 4'd0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (owner_q == OWN_LS)
                  ls_rdata_d = mem_rdata;
               else
                  if_rdata_d = mem_rdata;
               state_d = S_RESP;
            end
         end
         default: begin
            owner_d = OWN_NONE;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         streak_q    <= 4'd0;
         mem_addr_q  <= '0;
         mem_wen_q   <= 1'b0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         mem_addr_q  <= mem_addr_d;
         mem_wen_q   <= mem_wen_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   // Accept pulses follow mem_ready combinationally so the requester sees them in the REQ cycle.
   assign mem_valid = (state_q == S_REQ);
   assign if_ready  = mem_valid && mem_ready && (owner_q == OWN_IF);
   assign ls_ready  = mem_valid && mem_ready && (owner_q == OWN_LS);
   assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
   assign ls_rvalid = (state_q == S_RESP) && (owner_q == OWN_LS);

   assign mem_addr  = mem_addr_q;
   assign mem_wen   = mem_wen_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wmask = mem_wmask_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a randomised memory model
module tb_mem_arbiter;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int MW   = DW / 8;
   localparam int MAXS = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_valid = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ready, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ls_valid = 1'b0;
   logic [AW-1:0] ls_addr = '0;
   logic          ls_wen = 1'b0;
   logic [DW-1:0] ls_wdata = '0;
   logic [MW-1:0] ls_wmask = '0;
   logic          ls_ready, ls_rvalid;
   logic [DW-1:0] ls_rdata;
   logic          mem_valid, mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_ready = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wen(ls_wen),
      .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_ready(ls_ready),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            is_ls;
      bit            is_store;
      logic [DW-1:0] data;
   } resp_t;

   resp_t         sb_q[$];
   bit            grant_log[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            streak_m = 0;
   bit            exp_req = 0, waiting = 0, cur_ls = 0, cur_store = 0;
   int            ready_cnt = 0, wait_cnt = 0, req_len = 0, last_req_len = 0;
   int            fixed_rdy = 0, fixed_wait = 0, p_new = 0;
   bit            hold_both = 0, stray_en = 0, use_fixed_rdata = 0;
   logic [DW-1:0] fixed_rdata = '0;
   int            issue_cyc = 0, resp_cyc = 0, mrv_cyc = 0;
   logic [9:0]    starve_pat;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Response monitor: every rvalid pulse must match the oldest scoreboard entry.
   always @(negedge clk) begin
      resp_t e;
      if (if_rvalid || ls_rvalid) begin
         resp_cyc = cyc;
         chk("rvalid_onehot", 64'(if_rvalid & ls_rvalid), 64'd0);
         if (sb_q.size() == 0) begin
            chk("unexpected_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rvalid_side", 64'(ls_rvalid), 64'(e.is_ls));
            if (!e.is_ls)
               chk("if_rdata", if_rdata, e.data);
            else if (!e.is_store)
               chk("ls_rdata", ls_rdata, e.data);
         end
      end
   end

   task automatic chk_payload();
      chk("mem_addr", mem_addr, cur_ls ? ls_addr : if_addr);
      chk("mem_wen", 64'(mem_wen), 64'(cur_ls ? ls_wen : 1'b0));
      chk("mem_wmask", 64'(mem_wmask), 64'(cur_ls ? ls_wmask : '0));
      if (cur_ls) chk("mem_wdata", mem_wdata, ls_wdata);
   endtask

   task automatic observe();
      bit exp_ls;
      if (exp_req) begin
         chk("mem_valid_held", 64'(mem_valid), 64'd1);
         if (mem_valid) chk_payload();
         req_len++;
      end else if (mem_valid) begin
         chk("grant_while_busy", 64'(waiting), 64'd0);
         chk("grant_has_request", 64'(if_valid | ls_valid), 64'd1);
         exp_ls = ls_valid && !(if_valid && streak_m == MAXS);
         if (exp_ls) streak_m = if_valid ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
         else        streak_m = 0;
         cur_ls    = exp_ls;
         cur_store = exp_ls && ls_wen;
         grant_log.push_back(exp_ls);
         exp_req   = 1;
         req_len   = 1;
         ready_cnt = (fixed_rdy >= 0) ? fixed_rdy : int'($urandom_range(0, 3));
         chk_payload();
      end
   endtask

   task automatic drive();
      bit acc_if, acc_ls;
      acc_if     = 0;
      acc_ls     = 0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (exp_req) begin
         if (ready_cnt == 0) begin
            mem_ready    = 1'b1;
            exp_req      = 0;
            waiting      = 1;
            last_req_len = req_len;
            wait_cnt     = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            acc_ls       = cur_ls;
            acc_if       = !cur_ls;
         end else begin
            ready_cnt--;
            if (stray_en && $urandom_range(0, 3) == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = {$urandom, $urandom};
            end
         end
      end else if (waiting) begin
         if (wait_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = use_fixed_rdata ? fixed_rdata : {$urandom, $urandom};
            sb_q.push_back('{is_ls: cur_ls, is_store: cur_store, data: mem_rdata});
            mrv_cyc    = cyc;
            waiting    = 0;
         end else begin
            wait_cnt--;
         end
      end
      if (acc_if) if_valid = 1'b0;
      if (acc_ls) ls_valid = 1'b0;
      if (!if_valid && (hold_both || $urandom_range(0, 99) < p_new)) begin
         if_valid = 1'b1;
         if_addr  = {$urandom, $urandom};
      end
      if (!ls_valid && (hold_both || $urandom_range(0, 99) < p_new)) begin
         ls_valid = 1'b1;
         ls_addr  = {$urandom, $urandom};
         ls_wen   = 1'($urandom_range(0, 1));
         ls_wdata = {$urandom, $urandom};
         ls_wmask = MW'($urandom_range(0, 255));
      end
   endtask

   task automatic step();
      @(negedge clk);
      observe();
      drive();
      #1;
      chk("if_ready", 64'(if_ready), 64'(mem_ready && !cur_ls));
      chk("ls_ready", 64'(ls_ready), 64'(mem_ready && cur_ls));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
      chk({tag, "_mem_addr"}, mem_addr, 64'd0);
      chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
      chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
      chk({tag, "_readys"}, 64'({if_ready, ls_ready}), 64'd0);
      chk({tag, "_rvalids"}, 64'({if_rvalid, ls_rvalid}), 64'd0);
      chk({tag, "_if_rdata"}, if_rdata, 64'd0);
      chk({tag, "_ls_rdata"}, ls_rdata, 64'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n      = 1'b0;
      if_valid   = 1'b0;
      ls_valid   = 1'b0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      exp_req    = 0;
      waiting    = 0;
      hold_both  = 0;
      streak_m   = 0;
      sb_q.delete();
      #1;
      chk_all_zero(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      p_new = 0;
      hold_both = 0;
      while ((if_valid || ls_valid || exp_req || waiting || sb_q.size() != 0) && n < 300) begin
         step();
         n++;
      end
      chk("drain_done", 64'(if_valid || ls_valid || exp_req || waiting || sb_q.size() != 0), 64'd0);
      step();
      step();
   endtask

   task automatic run_starve(input int n);
      int k;
      grant_log.delete();
      fixed_rdy  = 0;
      fixed_wait = 0;
      hold_both  = 1;
      k = 0;
      while (grant_log.size() < n && k < 200) begin
         step();
         k++;
      end
      hold_both = 0;
      chk("starve_grants_seen", 64'(grant_log.size() >= n), 64'd1);
      for (int i = 0; i < n && i < grant_log.size(); i++)
         chk($sformatf("grant_%0d_is_ls", i), 64'(grant_log[i]), 64'(starve_pat[i]));
      drain();
   endtask

   initial begin
      starve_pat = 10'b0111101111;

      // Reset with requests and memory handshakes active.
      if_valid  = 1'b1;
      ls_valid  = 1'b1;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("in_reset");
      do_reset("reset");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_mem_valid", 64'(mem_valid), 64'd0);
      end

      // Single fetch, immediate memory.
      fixed_rdy       = 0;
      fixed_wait      = 0;
      use_fixed_rdata = 1;
      fixed_rdata     = 64'h0000001300000093;
      if_valid  = 1'b1;
      if_addr   = 64'h80000000;
      issue_cyc = cyc;
      repeat (6) step();
      chk("fetch_latency", 64'(resp_cyc - issue_cyc), 64'd3);
      chk("fetch_if_rdata_held", if_rdata, 64'h0000001300000093);
      chk("fetch_ls_rdata", ls_rdata, 64'd0);
      use_fixed_rdata = 0;

      // Store with mem_ready held off for three cycles.
      fixed_rdy  = 3;
      fixed_wait = 1;
      ls_valid = 1'b1;
      ls_addr  = 64'h80001004;
      ls_wen   = 1'b1;
      ls_wdata = 64'hDEADBEEF;
      ls_wmask = 8'hF0;
      repeat (10) step();
      chk("store_req_len", 64'(last_req_len), 64'd4);
      chk("store_rvalid_lat", 64'(resp_cyc - mrv_cyc), 64'd1);

      // Starvation guard from a fresh streak.
      do_reset("pre_starve");
      run_starve(10);

      // Reset while waiting for the memory response.
      fixed_rdy  = 0;
      fixed_wait = 6;
      if_valid = 1'b1;
      if_addr  = 64'h80000040;
      for (int i = 0; i < 20 && !waiting; i++) step();
      chk("reached_wait", 64'(waiting), 64'd1);
      step();
      #2;
      do_reset("mid_wait");
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBAD0BAD0BAD0BAD0;
      repeat (4) step();
      run_starve(5);

      // Randomised traffic with stray responses during REQ.
      fixed_rdy  = -1;
      fixed_wait = -1;
      stray_en   = 1;
      p_new      = 40;
      repeat (1500) step();
      drain();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
